// File: rtl/grey_code_n.sv
// Gray-code up/down counter driven by asynchronous edge requests, with
// synchronous load, wrap/saturate ends and a post-reset hold window.
module grey_code_n #(
  parameter int WIDTH       = 6,
  parameter int SYNC_STAGES = 3,
  parameter bit WRAP        = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             incr,
  input  logic             decr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] grey,
  output logic [WIDTH-1:0] bin,
  output logic             step,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] DN_RST  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [3:0]       HOLD_CYCLES = 4'd8;

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [3:0]             hold_q;
  logic                   hold_active;
  logic [SYNC_STAGES:0]   incr_sync_q, decr_sync_q;
  logic                   incr_req, decr_req;
  logic [WIDTH-1:0]       bin_q, bin_d, grey_q, grey_d;
  logic [WIDTH-1:0]       up_grey_q, up_grey_d, dn_grey_q, dn_grey_d;
  logic                   step_q, step_d, at_max_q, at_max_d, at_min_q, at_min_d;

  assign hold_active = (hold_q != HOLD_CYCLES);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q <= 4'd0;
    end else if (hold_active) begin
      hold_q <= hold_q + 4'd1;
    end
  end

  // Top bit of each chain is the edge-detect flop; the chains stay cleared while holding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      incr_sync_q <= '0;
      decr_sync_q <= '0;
    end else if (hold_active) begin
      incr_sync_q <= '0;
      decr_sync_q <= '0;
    end else begin
      incr_sync_q <= {incr_sync_q[SYNC_STAGES-1:0], incr};
      decr_sync_q <= {decr_sync_q[SYNC_STAGES-1:0], decr};
    end
  end

  assign incr_req = incr_sync_q[SYNC_STAGES-1] & ~incr_sync_q[SYNC_STAGES];
  assign decr_req = decr_sync_q[SYNC_STAGES-1] & ~decr_sync_q[SYNC_STAGES];

  // NOTE: every comb output gets a default first so no latch is inferred.
  always_comb begin
    bin_d  = bin_q;
    grey_d = grey_q;
    step_d = 1'b0;
    if (!hold_active) begin
      if (load) begin
        bin_d  = load_val;
        grey_d = to_gray(load_val);
      end else if (incr_req && decr_req) begin
        bin_d = bin_q;
      end else if (incr_req) begin
        if (WRAP || (bin_q != MAX_VAL)) begin
          bin_d  = bin_q + ONE;
          grey_d = up_grey_q;
          step_d = 1'b1;
        end
      end else if (decr_req) begin
        if (WRAP || (bin_q != '0)) begin
          bin_d  = bin_q - ONE;
          grey_d = dn_grey_q;
          step_d = 1'b1;
        end
      end
    end
    up_grey_d = to_gray(bin_d + ONE);
    dn_grey_d = to_gray(bin_d - ONE);
    at_max_d  = (bin_d == MAX_VAL);
    at_min_d  = (bin_d == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_q     <= '0;
      grey_q    <= '0;
      up_grey_q <= ONE;
      dn_grey_q <= DN_RST;
      step_q    <= 1'b0;
      at_max_q  <= 1'b0;
      at_min_q  <= 1'b1;
    end else begin
      bin_q     <= bin_d;
      grey_q    <= grey_d;
      up_grey_q <= up_grey_d;
      dn_grey_q <= dn_grey_d;
      step_q    <= step_d;
      at_max_q  <= at_max_d;
      at_min_q  <= at_min_d;
    end
  end

  assign grey   = grey_q;
  assign bin    = bin_q;
  assign step   = step_q;
  assign at_max = at_max_q;
  assign at_min = at_min_q;

endmodule

// File: doc/grey_code_n.md
GREY_CODE_N -- requirements
Module: grey_code_n

Interface
REQ-001 Parameter WIDTH, default 6, counter width in bits, legal range 2..16.
REQ-002 Parameter SYNC_STAGES, default 3, synchroniser depth for incr/decr, legal range 2..4.
REQ-003 Parameter WRAP, default 1: 1 = modulo-2^WIDTH wrap, 0 = saturate at ends.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset (low = reset asserted).
REQ-006 incr  input  1  asynchronous step-up request, edge-sensitive.
REQ-007 decr  input  1  asynchronous step-down request, edge-sensitive.
REQ-008 load  input  1  clk-synchronous load strobe.
REQ-009 load_val  input  WIDTH  binary value to load.
REQ-010 grey  output  WIDTH  registered Gray-code count.
REQ-011 bin  output  WIDTH  registered binary equivalent of grey.
REQ-012 step  output  1  one-cycle pulse, high in the cycle after grey changes due to incr/decr.
REQ-013 at_max  output  1  registered, high when bin == 2^WIDTH-1.
REQ-014 at_min  output  1  registered, high when bin == 0.

Function
REQ-015 Internal hold counter: after rst deasserts, block SHALL ignore incr, decr and load for exactly 8 rising clk edges; first accepted action at edge 9.
REQ-016 During hold, synchroniser chains SHALL be forced to 0.
REQ-017 incr and decr each SHALL pass through SYNC_STAGES flops plus one edge-detect flop; request = stage[SYNC_STAGES-1] & ~stage[SYNC_STAGES].
REQ-018 Latency: with edge 1 the first edge sampling incr high, grey SHALL update at edge SYNC_STAGES+1 (edge 4 at default).
REQ-019 An input held high across the end of hold SHALL produce exactly one step.
REQ-020 A held-high level SHALL produce one step only; no further step until low then high again.
REQ-021 Gray invariant: consecutive grey values produced by a step SHALL differ in exactly one bit.
REQ-022 grey SHALL equal bin ^ (bin >> 1) at all times.
REQ-023 Next-up and next-down Gray values SHALL be precomputed registers, so grey is loaded directly from a flop on a step.
REQ-024 Priority per edge: load > (incr and decr requests in same cycle) > single request.
REQ-025 load SHALL set bin = load_val and grey = Gray(load_val) on the next edge; step SHALL NOT pulse for a load.
REQ-026 Coincident incr and decr requests SHALL cancel: no count change, no step pulse.
REQ-027 WRAP=1: incr at 2^WIDTH-1 SHALL go to 0; decr at 0 SHALL go to 2^WIDTH-1; step pulses.
REQ-028 WRAP=0: incr at 2^WIDTH-1 and decr at 0 SHALL leave the count unchanged, step SHALL NOT pulse.
REQ-029 at_max/at_min SHALL update in the same cycle as grey/bin.
REQ-030 load_val is accepted at full WIDTH; no truncation or range check.

Reset
REQ-031 On rst low, asynchronously: grey=0, bin=0, step=0, at_max=0, at_min=1, synchronisers and edge flops=0, hold counter restarts.
REQ-032 Reset asserted mid-step or mid-synchronisation SHALL discard the pending request; no step after release unless the input is still high (REQ-019).
REQ-033 Outputs SHALL hold reset values until the first accepted action after hold.

Verification
REQ-034 WIDTH=6 default; release rst, pulse incr 3 cycles, 20 times -> grey walks 00,01,03,02,06,..., bin=20, each grey change 1 bit, step pulses 20 times, 4th-edge latency each.
REQ-035 WRAP=1, load 63 -> at_max=1, grey=0x20; one incr pulse -> bin=0, grey=0, at_min=1, step=1; one decr pulse -> bin=63.
REQ-036 WRAP=0, load 63; incr pulse -> bin stays 63, step=0; load 0, decr pulse -> bin stays 0, step=0.
REQ-037 incr and decr rising in same cycle -> bin unchanged, step=0; load asserted in same cycle as a pending request -> load_val wins, step=0.
REQ-038 incr held high through rst release -> exactly one step, at edge 12 after release (8 hold + 4 latency); incr pulse during hold cycles 1-7 then low -> no step.
REQ-039 rst pulsed low between incr sampling and update, count at 10 -> grey=0, bin=0 asynchronously, no step afterwards with incr low.
